// File: rtl/pwm_pkg.sv
// Shared constants for the PWM register bank: channel/width defaults and register map.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwm_pkg;

  localparam int NCH_DEF = 4;
  localparam int CW_DEF  = 16;

  // Register select is adr[3:2] within a channel's 16-byte window.
  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_PERIOD = 2'd1,
    REG_DUTY   = 2'd2,
    REG_STATUS = 2'd3
  } reg_sel_e;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int STAT_PEND   = 0;
  localparam int STAT_WRAP   = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } wb_state_e;

  // Expand per-byte selects into a 32-bit write mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/pwm_wb_regs_if.sv
// Wishbone slave bus bundle between the caravel management core and the PWM register bank.
// Latency: n/a (wiring only).
// Backpressure: slave holds ack low until it is ready; master keeps stb until ack.
interface pwm_wb_regs_if;

  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/pwm_ch_regs.sv
// One PWM channel: CTRL bits, staged/active period+duty, pend and wrap flags, commit with clamp.
// Latency: writes land on the strobe edge; commit one edge later (en=0) or on the wrap edge (en=1).
// Backpressure: none; every strobe is absorbed in the cycle it arrives.
module pwm_ch_regs
  import pwm_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_ctrl,
  input  logic          wr_period,
  input  logic          wr_duty,
  input  logic          wr_status,
  input  logic [31:0]   wdat,
  input  logic [3:0]    wsel,
  input  logic          wrap_in,
  output logic          en,
  output logic          irq_en,
  output logic [CW-1:0] stg_period,
  output logic [CW-1:0] stg_duty,
  output logic [CW-1:0] act_period,
  output logic [CW-1:0] act_duty,
  output logic          pend,
  output logic          wrap
);

  logic [31:0]   mask;
  logic [CW-1:0] period_nxt;
  logic [CW-1:0] duty_nxt;
  logic [CW-1:0] duty_clamped;
  logic          commit;
  logic          wrap_set;
  logic          wrap_clr;
  logic          unused_ok;

  // Bits of the bus word above CW are dropped.
  assign unused_ok = ^{mask, wdat};

  // Byte-merge the write data into staging; clamp duty to period for the commit path.
  always_comb begin
    mask         = byte_mask(wsel);
    period_nxt   = (stg_period & ~mask[CW-1:0]) | (wdat[CW-1:0] & mask[CW-1:0]);
    duty_nxt     = (stg_duty & ~mask[CW-1:0]) | (wdat[CW-1:0] & mask[CW-1:0]);
    duty_clamped = (stg_duty > stg_period) ? stg_period : stg_duty;
  end

  // A disabled channel commits as soon as something is pending; an enabled one waits for wrap.
  assign commit   = pend & (~en | wrap_in);
  assign wrap_set = wrap_in & en;
  assign wrap_clr = wr_status & wsel[0] & wdat[STAT_WRAP];

  // CTRL register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en     <= 1'b0;
      irq_en <= 1'b0;
    end else if (wr_ctrl && wsel[0]) begin
      en     <= wdat[CTRL_EN];
      irq_en <= wdat[CTRL_IRQ_EN];
    end
  end

  // Staging values track writes directly so readback shows the raw value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_period <= '0;
      stg_duty   <= '0;
    end else begin
      if (wr_period) stg_period <= period_nxt;
      if (wr_duty)   stg_duty   <= duty_nxt;
    end
  end

  // Commit copies the pre-write staging; a write on the same edge keeps pend set for next time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_period <= '0;
      act_duty   <= '0;
      pend       <= 1'b0;
    end else begin
      if (commit) begin
        act_period <= stg_period;
        act_duty   <= duty_clamped;
      end
      if (wr_period || wr_duty) pend <= 1'b1;
      else if (commit)          pend <= 1'b0;
    end
  end

  // Wrap flag: set beats a simultaneous write-1-to-clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wrap <= 1'b0;
    else     wrap <= wrap_set | (wrap & ~wrap_clr);
  end

endmodule

// File: rtl/pwm_wb_regs.sv
// Wishbone register bank configuring NCH PWM channels with wrap-synchronised commit and IRQ.
// Latency: ack and read data one cycle after stb; irq one cycle after the wrap flag changes.
// Backpressure: one transfer per two cycles (ack never back-to-back); off-base cycles never acked.
module pwm_wb_regs
  import pwm_pkg::*;
#(
  parameter int          NCH       = NCH_DEF,
  parameter int          CW        = CW_DEF,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  pwm_wb_regs_if.slave      wb,
  input  logic [NCH-1:0]    pwm_wrap_i,
  output logic [NCH-1:0]    pwm_en_o,
  output logic [NCH*CW-1:0] pwm_period_o,
  output logic [NCH*CW-1:0] pwm_duty_o,
  output logic              irq_o
);

  wb_state_e      state;
  wb_state_e      state_nxt;
  logic           hit;
  logic           go;
  logic           wr_go;
  reg_sel_e       reg_sel;
  logic [7:0]     ch_field;
  logic [NCH-1:0] ch_hit;
  logic [NCH-1:0] wrap_v;
  logic [NCH-1:0] irq_en_v;
  logic [31:0]    rd_word [NCH];
  logic [31:0]    rd_mux;
  logic [31:0]    rdata;
  logic           unused_ok;

  assign unused_ok = ^{wb.wbs_adr_i[1:0]};

  assign hit      = wb.wbs_cyc_i & wb.wbs_stb_i & (wb.wbs_adr_i[31:12] == BASE_ADDR[31:12]);
  assign go       = (state == ST_IDLE) & hit;
  assign wr_go    = go & wb.wbs_we_i;
  assign reg_sel  = reg_sel_e'(wb.wbs_adr_i[3:2]);
  assign ch_field = wb.wbs_adr_i[11:4];

  // Handshake state register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state and ack: ACK lasts exactly one cycle, always returning to IDLE.
  always_comb begin
    state_nxt    = state;
    wb.wbs_ack_o = 1'b0;
    case (state)
      ST_IDLE: if (go) state_nxt = ST_ACK;
      ST_ACK: begin
        wb.wbs_ack_o = 1'b1;
        state_nxt    = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic          en;
    logic          irq_en;
    logic          pend;
    logic          wrap;
    logic [CW-1:0] stg_period;
    logic [CW-1:0] stg_duty;

    assign ch_hit[c] = (ch_field == 8'(c));

    pwm_ch_regs #(.CW(CW)) u_ch (
      .clk        (wb_clk_i),
      .rst        (wb_rst_i),
      .wr_ctrl    (wr_go & ch_hit[c] & (reg_sel == REG_CTRL)),
      .wr_period  (wr_go & ch_hit[c] & (reg_sel == REG_PERIOD)),
      .wr_duty    (wr_go & ch_hit[c] & (reg_sel == REG_DUTY)),
      .wr_status  (wr_go & ch_hit[c] & (reg_sel == REG_STATUS)),
      .wdat       (wb.wbs_dat_i),
      .wsel       (wb.wbs_sel_i),
      .wrap_in    (pwm_wrap_i[c]),
      .en         (en),
      .irq_en     (irq_en),
      .stg_period (stg_period),
      .stg_duty   (stg_duty),
      .act_period (pwm_period_o[c*CW +: CW]),
      .act_duty   (pwm_duty_o[c*CW +: CW]),
      .pend       (pend),
      .wrap       (wrap)
    );

    assign pwm_en_o[c] = en;
    assign wrap_v[c]   = wrap;
    assign irq_en_v[c] = irq_en;

    // Per-channel readback word for the selected register.
    always_comb begin
      rd_word[c] = '0;
      case (reg_sel)
        REG_CTRL: begin
          rd_word[c][CTRL_EN]     = en;
          rd_word[c][CTRL_IRQ_EN] = irq_en;
        end
        REG_PERIOD: rd_word[c] = 32'(stg_period);
        REG_DUTY:   rd_word[c] = 32'(stg_duty);
        REG_STATUS: begin
          rd_word[c][STAT_PEND] = pend;
          rd_word[c][STAT_WRAP] = wrap;
        end
        default: rd_word[c] = '0;
      endcase
    end
  end

  // Channel select; offsets beyond the last channel fall through as zero.
  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NCH; c++) begin
      if (ch_hit[c]) rd_mux = rd_word[c];
    end
  end

  // Read data is captured on the strobe edge and forced to zero outside the ack cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)               rdata <= '0;
    else if (go && !wb.wbs_we_i) rdata <= rd_mux;
    else                         rdata <= '0;
  end

  assign wb.wbs_dat_o = rdata;

  // Registered interrupt: any enabled channel with its wrap flag up.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) irq_o <= 1'b0;
    else          irq_o <= |(wrap_v & irq_en_v);
  end

endmodule

// File: tb/tb_pwm_wb_regs.sv
module tb_pwm_wb_regs;

  localparam int          NCH  = 4;
  localparam int          CW   = 16;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwm_wb_regs_if bus ();
  logic [NCH-1:0]    wrap_in;
  logic [NCH-1:0]    en_o;
  logic [NCH*CW-1:0] per_o;
  logic [NCH*CW-1:0] duty_o;
  logic              irq_o;

  pwm_wb_regs #(.NCH(NCH), .CW(CW), .BASE_ADDR(BASE)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .wb           (bus),
    .pwm_wrap_i   (wrap_in),
    .pwm_en_o     (en_o),
    .pwm_period_o (per_o),
    .pwm_duty_o   (duty_o),
    .irq_o        (irq_o)
  );

  int checks   = 0;
  int failures = 0;
  bit rnd_wrap = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: per-channel register contents as plain numbers.
  bit          m_en [NCH];
  bit          m_ien [NCH];
  bit          m_pend [NCH];
  bit          m_wrap [NCH];
  int unsigned m_sp [NCH];
  int unsigned m_sd [NCH];
  int unsigned m_ap [NCH];
  int unsigned m_ad [NCH];
  bit          m_ack;
  bit          m_irq;
  int unsigned m_rd;

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_en[c] = 0; m_ien[c] = 0; m_pend[c] = 0; m_wrap[c] = 0;
      m_sp[c] = 0; m_sd[c] = 0; m_ap[c] = 0; m_ad[c] = 0;
    end
    m_ack = 0; m_irq = 0; m_rd = 0;
  endfunction

  function automatic int unsigned merge(input int unsigned old, input int unsigned dat,
                                        input logic [3:0] sel);
    int unsigned r = old;
    if (sel[0]) r = (r & ~32'h0000_00FF) | (dat & 32'h0000_00FF);
    if (sel[1]) r = (r & ~32'h0000_FF00) | (dat & 32'h0000_FF00);
    return r & 32'h0000_FFFF;
  endfunction

  function automatic int unsigned rd_model(input int unsigned off);
    int unsigned c = off / 16;
    int unsigned r = (off / 4) % 4;
    if (c >= NCH) return 0;
    case (r)
      0: return m_en[c] + 2 * m_ien[c];
      1: return m_sp[c];
      2: return m_sd[c];
      default: return m_pend[c] + 2 * m_wrap[c];
    endcase
  endfunction

  task automatic model_step();
    bit          go;
    bit          new_irq;
    int unsigned off;
    int unsigned c_sel;
    int unsigned r_sel;
    int unsigned dat;
    logic [3:0]  sel;
    if (rst) begin
      model_reset();
      return;
    end
    go    = bus.wbs_cyc_i && bus.wbs_stb_i && (bus.wbs_adr_i[31:12] == BASE[31:12]) && !m_ack;
    off   = 32'(bus.wbs_adr_i[11:0]);
    c_sel = off / 16;
    r_sel = (off / 4) % 4;
    dat   = bus.wbs_dat_i;
    sel   = bus.wbs_sel_i;
    new_irq = 0;
    for (int c = 0; c < NCH; c++) if (m_wrap[c] && m_ien[c]) new_irq = 1;
    m_rd = (go && !bus.wbs_we_i) ? rd_model(off) : 0;
    for (int c = 0; c < NCH; c++) begin
      bit wr;
      bit commit;
      bit clr_w;
      wr     = go && bus.wbs_we_i && (c_sel == c);
      commit = m_pend[c] && (!m_en[c] || wrap_in[c]);
      clr_w  = wr && (r_sel == 3) && sel[0] && dat[1];
      if (commit) begin
        m_ap[c]   = m_sp[c];
        m_ad[c]   = (m_sd[c] < m_sp[c]) ? m_sd[c] : m_sp[c];
        m_pend[c] = 0;
      end
      m_wrap[c] = (wrap_in[c] && m_en[c]) || (m_wrap[c] && !clr_w);
      if (wr) begin
        case (r_sel)
          0: if (sel[0]) begin m_en[c] = dat[0]; m_ien[c] = dat[1]; end
          1: begin m_sp[c] = merge(m_sp[c], dat, sel); m_pend[c] = 1; end
          2: begin m_sd[c] = merge(m_sd[c], dat, sel); m_pend[c] = 1; end
          default: ;
        endcase
      end
    end
    m_irq = new_irq;
    m_ack = go;
  endtask

  task automatic compare_all();
    logic [NCH-1:0]    e_en;
    logic [NCH*CW-1:0] e_per;
    logic [NCH*CW-1:0] e_duty;
    for (int c = 0; c < NCH; c++) begin
      e_en[c]            = m_en[c];
      e_per[c*CW +: CW]  = m_ap[c][CW-1:0];
      e_duty[c*CW +: CW] = m_ad[c][CW-1:0];
    end
    chk("ack", bus.wbs_ack_o, m_ack);
    chk("rdata", bus.wbs_dat_o, m_rd);
    chk("pwm_en", en_o, e_en);
    chk("pwm_period", per_o, e_per);
    chk("pwm_duty", duty_o, e_duty);
    chk("irq", irq_o, m_irq);
  endtask

  // One clock: model advances on the same edge as the DUT, outputs compared 1ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    wrap_in = rnd_wrap ? 4'($urandom_range(0, 15) & $urandom_range(0, 15)) : '0;
  endtask

  task automatic wb_xfer(input logic [31:0] adr, input bit we, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [NCH-1:0] wrapv,
                         output logic [31:0] rdat);
    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr; bus.wbs_dat_i = dat; bus.wbs_sel_i = sel;
    wrap_in = wrapv;
    tick();
    rdat = bus.wbs_dat_o;
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
    tick();
  endtask

  task automatic wb_write(input logic [31:0] off, input logic [31:0] dat,
                          input logic [3:0] sel, input logic [NCH-1:0] wrapv);
    logic [31:0] dummy;
    wb_xfer(BASE + off, 1'b1, dat, sel, wrapv, dummy);
  endtask

  task automatic wb_read(input logic [31:0] off, output logic [31:0] rdat);
    wb_xfer(BASE + off, 1'b0, 32'h0, 4'hF, '0, rdat);
  endtask

  initial begin
    logic [31:0] rd;
    model_reset();
    rst = 1;
    wrap_in = '0;
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
    bus.wbs_sel_i = 0; bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
    repeat (3) tick();
    rst = 0;
    tick();

    // Disabled channel commits one edge after each write.
    wb_write(32'h04, 32'd100, 4'hF, '0);
    wb_write(32'h08, 32'd25, 4'hF, '0);
    chk("t1_period0", per_o[15:0], 16'd100);
    chk("t1_duty0", duty_o[15:0], 16'd25);
    wb_read(32'h0C, rd);
    chk("t1_pend0", rd, 32'h0);

    // Enabled channel holds the new duty until its wrap pulse.
    wb_write(32'h00, 32'h1, 4'hF, '0);
    wb_write(32'h08, 32'd50, 4'hF, '0);
    chk("t2_duty_held", duty_o[15:0], 16'd25);
    wb_read(32'h0C, rd);
    chk("t2_pend_set", rd, 32'h1);
    wrap_in = 4'b0001;
    tick();
    chk("t2_duty_commit", duty_o[15:0], 16'd50);
    wb_read(32'h0C, rd);
    chk("t2_pend_clr", rd, 32'h2);

    // Duty above period is clamped on the active side only.
    wb_write(32'h14, 32'd200, 4'hF, '0);
    wb_write(32'h18, 32'd300, 4'hF, '0);
    chk("t3_duty_clamp", duty_o[31:16], 16'd200);
    wb_read(32'h18, rd);
    chk("t3_duty_raw", rd, 32'd300);

    // Wrap interrupt, W1C clear, and set winning over a same-cycle clear.
    wb_write(32'h20, 32'h3, 4'hF, '0);
    wrap_in = 4'b0100;
    tick();
    tick();
    chk("t4_irq_set", irq_o, 1'b1);
    wb_write(32'h2C, 32'h2, 4'hF, '0);
    chk("t4_irq_clr", irq_o, 1'b0);
    wrap_in = 4'b0100;
    tick();
    tick();
    wb_write(32'h2C, 32'h2, 4'hF, 4'b0100);
    chk("t4_irq_set_wins", irq_o, 1'b1);

    // Byte-select merge and unmapped offsets.
    wb_write(32'h34, 32'h1234, 4'hF, '0);
    wb_write(32'h34, 32'hFFFF_FFFF, 4'b0001, '0);
    wb_read(32'h34, rd);
    chk("t5_sel_merge", rd, 32'h12FF);
    wb_read(32'h3C, rd);
    chk("t5_status3", rd, 32'h0);
    wb_read(32'h44, rd);
    chk("t5_unmapped", rd, 32'h0);
    wb_xfer(BASE + 32'h1000, 1'b0, 32'h0, 4'hF, '0, rd);
    chk("t5_offbase_noack", rd, 32'h0);

    // Randomized traffic with random wrap pulses against the model.
    rnd_wrap = 1;
    for (int i = 0; i < 400; i++) begin
      int unsigned ch;
      int unsigned rg;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      ch  = $urandom_range(0, 4);
      rg  = $urandom_range(0, 3);
      adr = BASE + 32'(ch * 16 + rg * 4);
      if ($urandom_range(0, 15) == 0) adr = 32'h3000_2000 + 32'(rg * 4);
      case (rg)
        1, 2:    dat = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 300);
        default: dat = $urandom;
      endcase
      sel = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      wb_xfer(adr, $urandom_range(0, 1) == 1, dat, sel, 4'($urandom_range(0, 15)), rd);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) tick();
    end
    rnd_wrap = 0;
    wrap_in  = '0;

    // Asynchronous reset during the ack cycle.
    wb_write(32'h00, 32'h3, 4'hF, '0);
    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0;
    bus.wbs_adr_i = BASE; bus.wbs_sel_i = 4'hF;
    tick();
    chk("t6_ack_before_rst", bus.wbs_ack_o, 1'b1);
    #2;
    rst = 1;
    #1;
    chk("t6_rst_ack", bus.wbs_ack_o, 1'b0);
    chk("t6_rst_dat", bus.wbs_dat_o, 32'h0);
    chk("t6_rst_en", en_o, '0);
    chk("t6_rst_period", per_o, '0);
    chk("t6_rst_duty", duty_o, '0);
    chk("t6_rst_irq", irq_o, 1'b0);
    model_reset();
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
    tick();
    tick();
    rst = 0;
    tick();
    wb_read(32'h00, rd);
    chk("t6_ctrl0_after_rst", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
